// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared types and board geometry for the memory bus responder
// Contents: cell_t (3-bit cell), address_t (5-bit row address), col_t (column pointer),
//           fsm_state_t (IDLE/CLEAR), default geometry ROWS and COLS.
package mem_bus_responder_pkg;

  localparam int ROWS = 32;
  localparam int COLS = 10;

  typedef logic [2:0] cell_t;
  typedef logic [4:0] address_t;
  typedef logic [3:0] col_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - pin bundle of the multiplexed start/we/cont memory bus
// Signals: bus_start, bus_we, bus_cont, bus_in[4:0] (address on start, data in [2:0] otherwise)
//          driven by the master; bus_out[2:0], bus_oe driven by the responder (slave).
interface mem_bus_responder_if;
  import mem_bus_responder_pkg::*;

  logic     bus_start;
  logic     bus_we;
  logic     bus_cont;
  address_t bus_in;
  cell_t    bus_out;
  logic     bus_oe;

  modport master (
    output bus_start, bus_we, bus_cont, bus_in,
    input  bus_out, bus_oe
  );

  modport slave (
    input  bus_start, bus_we, bus_cont, bus_in,
    output bus_out, bus_oe
  );

endinterface

// File: rtl/mem_bus_row_store.sv
// rtl/mem_bus_row_store.sv - ROWS x COLS array of 3-bit cells with one write port, a whole-row clear and a combinational read
// Ports: clk; wr_en/wr_row/wr_col/wr_data single-cell write; clr_en/clr_row zero an entire row;
//        rd_row/rd_col -> rd_data (zero latency).
// Build option: MEM_BUS_RANGE_EN restricts reads/writes to rows below VALID_ROWS.
module mem_bus_row_store #(
  parameter int ROWS       = mem_bus_responder_pkg::ROWS,
  parameter int COLS       = mem_bus_responder_pkg::COLS,
  parameter int VALID_ROWS = 20
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  mem_bus_responder_pkg::address_t wr_row,
  input  mem_bus_responder_pkg::col_t     wr_col,
  input  mem_bus_responder_pkg::cell_t    wr_data,
  input  logic                            clr_en,
  input  mem_bus_responder_pkg::address_t clr_row,
  input  mem_bus_responder_pkg::address_t rd_row,
  input  mem_bus_responder_pkg::col_t     rd_col,
  output mem_bus_responder_pkg::cell_t    rd_data
);
  import mem_bus_responder_pkg::*;

`ifdef MEM_BUS_RANGE_EN
  // Rows at or above the playfield limit behave as hard-wired zero.
  localparam int ROW_LIMIT = (VALID_ROWS < ROWS) ? VALID_ROWS : ROWS;
`else
  localparam int ROW_LIMIT = ROWS;
`endif

  // Cells are deliberately left without reset: a reset does not wipe the board.
  cell_t mem [ROWS][COLS];

  function automatic logic row_ok(input address_t r);
    return int'(r) < ROW_LIMIT;
  endfunction

  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int c = 0; c < COLS; c++) begin
        mem[clr_row][c] <= '0;
      end
    end else if (wr_en && row_ok(wr_row)) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = row_ok(rd_row) ? mem[rd_row][rd_col] : '0;

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - pin-level responder for the start/we/cont memory bus with a row-sweep board clear
// Ports: clk, rst (async, active-high); bus (mem_bus_responder_if.slave: start/we/cont/in -> out/oe);
//        clear_req pulse starts a ROWS-cycle clear sweep; busy high during the sweep;
//        xfer_cnt counts accepted conts, wrapping at 256.
// Build option: MEM_BUS_RANGE_EN (rows >= VALID_ROWS read 0 and ignore writes).
module mem_bus_responder #(
  parameter int ROWS       = mem_bus_responder_pkg::ROWS,
  parameter int COLS       = mem_bus_responder_pkg::COLS,
  parameter int VALID_ROWS = 20
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_responder_if.slave bus,
  input  logic               clear_req,
  output logic               busy,
  output logic [7:0]         xfer_cnt
);
  import mem_bus_responder_pkg::*;

  fsm_state_t state;
  address_t   row;
  address_t   clr_row;
  col_t       col;
  logic       writing;
  logic       txn_open;   // distinguishes "no transaction since reset" from an open read
  logic       cont_acc;
  logic       store_we;
  cell_t      rd_data;

  // Start always wins over a coincident cont.
  assign cont_acc = bus.bus_cont && !bus.bus_start;
  // Pointers keep moving during a clear, only the store write is suppressed.
  assign store_we = cont_acc && writing && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      clr_row  <= '0;
      row      <= '0;
      col      <= '0;
      writing  <= 1'b0;
      txn_open <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (bus.bus_start) begin
        row      <= bus.bus_in;
        col      <= '0;
        writing  <= bus.bus_we;
        txn_open <= 1'b1;
      end else if (bus.bus_cont) begin
        col      <= (col == col_t'(COLS - 1)) ? '0 : col + 1'b1;
        xfer_cnt <= xfer_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_row <= '0;
          end
        end
        ST_CLEAR: begin
          // clear_req is not looked at here, so the sweep cannot restart.
          if (clr_row == address_t'(ROWS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_row <= clr_row + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_bus_row_store #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .VALID_ROWS (VALID_ROWS)
  ) u_row_store (
    .clk     (clk),
    .wr_en   (store_we),
    .wr_row  (row),
    .wr_col  (col),
    .wr_data (cell_t'(bus.bus_in[2:0])),
    .clr_en  (busy),
    .clr_row (clr_row),
    .rd_row  (row),
    .rd_col  (col),
    .rd_data (rd_data)
  );

  assign bus.bus_out = busy ? '0 : rd_data;
  assign bus.bus_oe  = txn_open && !writing && !bus.bus_start && !busy;

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  ROWS, 32, number of board rows stored.
  COLS, 10, cells per row.
  VALID_ROWS, 20, rows below this index are playfield (used only under MEM_BUS_RANGE_EN).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  input  1  single clock; all state changes on rising edge.
  rst  input  1  reset, asynchronous and active-high.
  bus_start  input  1  begin transaction; bus_in[4:0] carries the row address this cycle.
  bus_we  input  1  sampled with bus_start; 1 = write transaction, 0 = read transaction.
  bus_cont  input  1  transfer one cell and advance the column.
  bus_in  input  5  address when bus_start=1; write data in [2:0] otherwise.
  bus_out  output  3  read data for the current cell.
  bus_oe  output  1  responder drives bus_out onto the shared pins.
  clear_req  input  1  single-cycle pulse requesting a full board clear.
  busy  output  1  clear sweep in progress.
  xfer_cnt  output  8  count of completed cont transfers, wrapping.

Function
REQ-003 The block SHALL be a pin-level responder for the multiplexed start/write-enable/cont memory bus: a 3-bit cell store organised as ROWS x COLS.
REQ-004 When bus_start=1, the block SHALL latch row = bus_in[4:0], set col = 0 and latch writing = bus_we, effective next cycle; bus_cont SHALL be ignored in that cycle.
REQ-005 When bus_cont=1 and bus_start=0 on a write transaction, the block SHALL store bus_in[2:0] into cell [row][col]; on either transaction type, col SHALL advance by 1.
REQ-006 col SHALL wrap from COLS-1 to 0; values COLS..15 SHALL never occur.
REQ-007 bus_out SHALL equal cell [row][col] combinationally (zero latency), so data is valid in the same cycle as the cont that consumes it.
REQ-008 bus_oe SHALL be 1 iff a read transaction is open and bus_start=0; it SHALL be 0 during write transactions, during any start cycle, and while busy=1.
REQ-009 If bus_start=1 and bus_cont=1 in the same cycle, start SHALL win: no write, no col advance.
REQ-010 clear_req SHALL move the FSM from IDLE to CLEAR; CLEAR SHALL zero one row per cycle, from row 0 to ROWS-1, then return to IDLE. busy SHALL be 1 exactly in CLEAR (ROWS cycles).
REQ-011 During CLEAR, bus writes SHALL be dropped and bus_out SHALL read 0. Start/cont SHALL still update row/col/writing, so a transaction in progress resumes correctly.
REQ-012 clear_req during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-013 xfer_cnt SHALL increment on every accepted cont (bus_cont=1, bus_start=0), including transfers during CLEAR, and SHALL wrap 255->0.

Reset
REQ-014 On rst, the block SHALL asynchronously set: FSM=IDLE, row=0, col=0, writing=0, xfer_cnt=0. Outputs SHALL then be busy=0, bus_oe=0, bus_out=cell[0][0].
REQ-015 Cell contents SHALL NOT be reset. rst asserted mid-transaction or mid-CLEAR SHALL abort it; a partially cleared board is acceptable.

Configuration
REQ-016 With MEM_BUS_RANGE_EN defined, rows >= VALID_ROWS SHALL read as 0 and ignore writes. Without it, all ROWS rows SHALL be fully readable and writable.

Structure
REQ-017 The shared package SHALL hold cell_t (3-bit), address_t (5-bit), and constants COLS and ROWS.
REQ-018 Storage plus the per-row clear SHALL live in one sub-module, mem_bus_row_store. The FSM, pointers and bus pin logic SHALL live in mem_bus_responder.

Verification
REQ-019 Write row 5: start with bus_in=5 and we=1, then 10 conts with data 1..7,1,2,3 -> a read of row 5 returns the same sequence, with bus_oe=1 on every read cont.
REQ-020 Wrap: on a read of row 3, 12 conts -> cells 0..9 then cells 0,1; xfer_cnt increases by 12.
REQ-021 Start and cont in the same cycle on a write -> no cell changes and col=0 next cycle.
REQ-022 clear_req after filling rows 0..31 -> busy=1 for exactly 32 cycles, a write issued during busy is dropped, and all cells read 0 afterward.
REQ-023 rst asserted mid-read (col=4) -> same-cycle bus_oe=0, and col=0, xfer_cnt=0 after release.
REQ-024 With MEM_BUS_RANGE_EN, write row 25 with 7s -> reads return 0; without the macro, the same test reads 7s.
